usb_rx_line_decoder: RTL and testbench

- Sits directly downstream of the D+/D- input synchronizers in the USB receive path. D+ idles high and D- idles low.
- Recovers bit timing from the synchronized line and decodes NRZI.
- Removes stuffed bits and detects end-of-packet (SE0, SE0, J).
- Delivers one decoded data bit per strobe to the downstream shift register / packet decoder.

---
 rtl/usb_rx_pkg.sv | 20 ++
 rtl/usb_rx_bit_timer.sv | 27 ++
 rtl/usb_rx_line_decoder.sv | 188 ++++++++++++++++++
 tb/tb_usb_rx_line_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive line decoder.
package usb_rx_pkg;

  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, EOP, ERR} rx_state_t;

  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] EOP_SE0_MIN  = 2'd2;
  localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Free-running bit-time counter; resync restarts the bit, sample_tick marks the sample point.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic resync,
  output logic sample_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst || resync)
      timer <= '0;
    else if (timer == TW'(CLKS_PER_BIT - 1))
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  assign sample_tick = (timer == TW'(SAMPLE_PT));

endmodule

// File: rtl/usb_rx_line_decoder.sv
// USB receive line decoder: bit recovery, NRZI decode, destuffing and EOP detection.
// Optional sync-pattern checking is enabled with USB_RX_SYNC_DETECT_EN.
import usb_rx_pkg::*;

module usb_rx_line_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  output logic rx_bit,
  output logic bit_strobe,
  output logic rx_active,
  output logic eop,
  output logic rx_err,
  output logic sync_found
);

  rx_state_t   state, state_n;
  line_state_t ls;
  logic        dp_q, prev_lvl, prev_n, dbit, k_edge, resync, sample_tick;
  logic [2:0]  ones_cnt, ones_n;
  logic [1:0]  se0_cnt, se0_n;
  logic        active_n, strobe_n, bit_n, eop_n, err_n;
`ifdef USB_RX_SYNC_DETECT_EN
  logic [3:0]  sync_cnt, sync_cnt_n;
  logic        sync_n;
`endif

  assign ls     = decode_line(d_plus_sync, d_minus_sync);
  assign dbit   = (d_plus_sync == prev_lvl);
  assign k_edge = (state == IDLE) && dp_q && (ls == K);
  // SE0 edges are not bit boundaries worth realigning to.
  assign resync = k_edge ||
                  ((state == ACTIVE) && (d_plus_sync != dp_q) && (ls != SE0));

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .resync     (resync),
    .sample_tick(sample_tick)
  );

  always_comb begin
    state_n  = state;
    prev_n   = prev_lvl;
    ones_n   = ones_cnt;
    se0_n    = se0_cnt;
    active_n = rx_active;
    strobe_n = 1'b0;
    bit_n    = rx_bit;
    eop_n    = 1'b0;
    err_n    = 1'b0;
`ifdef USB_RX_SYNC_DETECT_EN
    sync_cnt_n = sync_cnt;
    sync_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (k_edge) begin
          state_n  = ACTIVE;
          active_n = 1'b1;
        end
      end
      ACTIVE: begin
        if (sample_tick) begin
          case (ls)
            J, K: begin
              prev_n = d_plus_sync;
              if (ones_cnt == STUFF_LIMIT) begin
                if (dbit) begin
                  err_n   = 1'b1;
                  state_n = ERR;
                end else begin
                  ones_n = '0;
                end
              end else begin
                ones_n = dbit ? ones_cnt + 3'd1 : 3'd0;
`ifdef USB_RX_SYNC_DETECT_EN
                if (!sync_cnt[3]) begin
                  sync_cnt_n = sync_cnt + 4'd1;
                  if (dbit != SYNC_PATTERN[3'd7 - sync_cnt[2:0]]) begin
                    err_n   = 1'b1;
                    state_n = ERR;
                  end else if (sync_cnt[2:0] == 3'd7) begin
                    sync_n = 1'b1;
                  end
                end else begin
                  strobe_n = 1'b1;
                  bit_n    = dbit;
                end
`else
                strobe_n = 1'b1;
                bit_n    = dbit;
`endif
              end
            end
            SE0: begin
              se0_n   = 2'd1;
              state_n = EOP;
            end
            default: begin
              err_n   = 1'b1;
              state_n = ERR;
            end
          endcase
        end
      end
      EOP: begin
        if (sample_tick) begin
          if (ls == SE0) begin
            se0_n = (se0_cnt == 2'd3) ? 2'd3 : se0_cnt + 2'd1;
          end else if ((ls == J) && (se0_cnt >= EOP_SE0_MIN)) begin
            eop_n   = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        // ERR waits for an SE0 sample directly followed by a J sample.
        if (sample_tick) begin
          if (ls == SE0)
            se0_n = 2'd1;
          else if ((ls == J) && (se0_cnt != 2'd0))
            state_n = IDLE;
          else
            se0_n = 2'd0;
        end
      end
    endcase
    if ((state != IDLE) && (state_n == IDLE)) begin
      active_n = 1'b0;
      prev_n   = 1'b1;
      ones_n   = '0;
      se0_n    = '0;
`ifdef USB_RX_SYNC_DETECT_EN
      sync_cnt_n = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dp_q       <= 1'b1;
      prev_lvl   <= 1'b1;
      ones_cnt   <= '0;
      se0_cnt    <= '0;
      rx_active  <= 1'b0;
      rx_bit     <= 1'b0;
      bit_strobe <= 1'b0;
      eop        <= 1'b0;
      rx_err     <= 1'b0;
`ifdef USB_RX_SYNC_DETECT_EN
      sync_cnt   <= '0;
      sync_found <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      dp_q       <= d_plus_sync;
      prev_lvl   <= prev_n;
      ones_cnt   <= ones_n;
      se0_cnt    <= se0_n;
      rx_active  <= active_n;
      rx_bit     <= bit_n;
      bit_strobe <= strobe_n;
      eop        <= eop_n;
      rx_err     <= err_n;
`ifdef USB_RX_SYNC_DETECT_EN
      sync_cnt   <= sync_cnt_n;
      sync_found <= sync_n;
`endif
    end
  end

`ifndef USB_RX_SYNC_DETECT_EN
  assign sync_found = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Bench for usb_rx_line_decoder: packets are built from data bits, NRZI/stuff encoded onto the line,
// and the strobed stream is compared with the original data.
module tb_usb_rx_line_decoder;

  localparam int CPB = 8;
`ifdef USB_RX_SYNC_DETECT_EN
  localparam int SYNC_STROBES = 0;
  localparam int SYNC_PULSE   = 1;
`else
  localparam int SYNC_STROBES = 8;
  localparam int SYNC_PULSE   = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dp  = 1'b1;
  logic dm  = 1'b0;
  logic rx_bit, bit_strobe, rx_active, eop, rx_err, sync_found;

  int checks = 0;
  int errors = 0;

  bit got_q[$];
  int n_eop = 0, n_err = 0, n_sync = 0, n_eop_active = 0;

  bit tb_data[$];
  bit tb_bits[$];
  bit tb_exp[$];
  bit tb_line[$];

  usb_rx_line_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_PT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_plus_sync (dp),
    .d_minus_sync(dm),
    .rx_bit      (rx_bit),
    .bit_strobe  (bit_strobe),
    .rx_active   (rx_active),
    .eop         (eop),
    .rx_err      (rx_err),
    .sync_found  (sync_found)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bit_strobe) got_q.push_back(rx_bit);
    if (eop) begin
      n_eop++;
      if (rx_active) n_eop_active++;
    end
    if (rx_err) n_err++;
    if (sync_found) n_sync++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input bit p, input bit m, input int n);
    dp = p;
    dm = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tb_bits.push_back(b[i]);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it; a toggle is forced after six 1s.
  task automatic encode(input bit stuff_en);
    bit lvl;
    int ones;
    lvl = 1'b1;
    ones = 0;
    tb_line.delete();
    foreach (tb_bits[i]) begin
      if (!tb_bits[i]) lvl = ~lvl;
      tb_line.push_back(lvl);
      ones = tb_bits[i] ? ones + 1 : 0;
      if (stuff_en && ones == 6) begin
        lvl = ~lvl;
        tb_line.push_back(lvl);
        ones = 0;
      end
    end
  endtask

  task automatic drive_line(input int jit);
    int n;
    foreach (tb_line[i]) begin
      n = CPB;
      if (jit >= 0 && i == jit) n = CPB + 2;
      else if (jit >= 0 && i == jit + 1) n = CPB - 2;
      hold(tb_line[i], ~tb_line[i], n);
    end
  endtask

  task automatic eop_seq(input int n_se0);
    repeat (n_se0) hold(1'b0, 1'b0, CPB);
    hold(1'b1, 1'b0, CPB);
    hold(1'b1, 1'b0, 3 * CPB);
  endtask

  task automatic run_packet(input string tag, input logic [7:0] sync_byte, input bit stuff_en,
                            input int n_se0, input int jit, input int exp_eop, input int exp_err,
                            input int exp_sync, input int exp_nbits);
    int base, e0, r0, s0, a0;
    tb_bits.delete();
    add_byte(sync_byte);
    foreach (tb_data[i]) tb_bits.push_back(tb_data[i]);
    tb_exp.delete();
    for (int i = SYNC_STROBES == 8 ? 0 : 8; i < tb_bits.size(); i++) tb_exp.push_back(tb_bits[i]);
    while (exp_nbits >= 0 && tb_exp.size() > exp_nbits) void'(tb_exp.pop_back());
    encode(stuff_en);
    base = got_q.size();
    e0 = n_eop; r0 = n_err; s0 = n_sync; a0 = n_eop_active;
    drive_line(jit);
    chk({tag, "_active"}, int'(rx_active), 1);
    eop_seq(n_se0);
    chk({tag, "_nstrobe"}, got_q.size() - base, tb_exp.size());
    foreach (tb_exp[i])
      if (base + i < got_q.size()) chk({tag, "_bit"}, int'(got_q[base + i]), int'(tb_exp[i]));
    chk({tag, "_eop"}, n_eop - e0, exp_eop);
    chk({tag, "_err"}, n_err - r0, exp_err);
    chk({tag, "_sync"}, n_sync - s0, exp_sync);
    chk({tag, "_eop_active"}, n_eop_active - a0, 0);
    chk({tag, "_idle"}, int'(rx_active), 0);
  endtask

  task automatic rand_data(input int nbytes);
    logic [7:0] b;
    tb_data.delete();
    for (int k = 0; k < nbytes; k++) begin
      b = 8'($urandom);
      for (int i = 0; i < 8; i++) tb_data.push_back(b[i]);
    end
  endtask

  initial begin
    logic [7:0] a5;
    repeat (3) @(negedge clk);
    chk("rst_active", int'(rx_active), 0);
    chk("rst_strobe", int'(bit_strobe), 0);
    chk("rst_bit", int'(rx_bit), 0);
    chk("rst_eop", int'(eop), 0);
    chk("rst_err", int'(rx_err), 0);
    chk("rst_sync", int'(sync_found), 0);
    rst = 1'b0;
    hold(1'b1, 1'b0, 2 * CPB);

    // sync + 0xA5
    a5 = 8'hA5;
    tb_data.delete();
    for (int i = 0; i < 8; i++) tb_data.push_back(a5[i]);
    run_packet("a5", 8'h80, 1'b1, 2, -1, 1, 0, SYNC_PULSE, -1);

    // seven ones, stuffed bit in the line
    tb_data.delete();
    repeat (7) tb_data.push_back(1'b1);
    run_packet("ones7", 8'h80, 1'b1, 2, -1, 1, 0, SYNC_PULSE, -1);

    // stuff violation: no stuffed transition after six ones
    tb_data.delete();
    repeat (6) tb_data.push_back(1'b1);
    run_packet("stuffviol", 8'h80, 1'b0, 2, -1, 0, 1, SYNC_PULSE, SYNC_STROBES + 5);

    // jitter: stretch a K, shorten the following J
    rand_data(2);
    run_packet("jitter", 8'h80, 1'b1, 2, 2, 1, 0, SYNC_PULSE, -1);

    // single SE0 then J
    rand_data(1);
    run_packet("se0x1", 8'h80, 1'b1, 1, -1, 0, 1, SYNC_PULSE, -1);

    // reset during the 5th line bit
    rand_data(1);
    tb_bits.delete();
    add_byte(8'h80);
    foreach (tb_data[i]) tb_bits.push_back(tb_data[i]);
    encode(1'b1);
    for (int i = 0; i < 4; i++) hold(tb_line[i], ~tb_line[i], CPB);
    hold(tb_line[4], ~tb_line[4], 4);
    rst = 1'b1;
    dp = 1'b1;
    dm = 1'b0;
    @(negedge clk);
    chk("midrst_active", int'(rx_active), 0);
    chk("midrst_strobe", int'(bit_strobe), 0);
    chk("midrst_eop", int'(eop), 0);
    chk("midrst_err", int'(rx_err), 0);
    rst = 1'b0;
    hold(1'b1, 1'b0, 3 * CPB);
    run_packet("restart", 8'h80, 1'b1, 2, -1, 1, 0, SYNC_PULSE, -1);

`ifdef USB_RX_SYNC_DETECT_EN
    rand_data(1);
    run_packet("badsync", 8'hC0, 1'b1, 2, -1, 0, 1, 0, 0);
`endif

    for (int p = 0; p < 6; p++) begin
      rand_data(int'($urandom_range(1, 3)));
      run_packet("rand", 8'h80, 1'b1, 2, -1, 1, 0, SYNC_PULSE, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
